// File: rtl/rtc_alarm_clock_pkg.sv
// Shared constants, field widths and alarm state type for the alarm clock.
package clock_pkg;
  localparam int HOURS_MAX = 23;
  localparam int MIN_MAX   = 59;
  localparam int SEC_MAX   = 59;
  localparam int H_W       = 5;
  localparam int MS_W      = 6;

  typedef enum logic {ALM_IDLE, ALM_RING} alm_state_t;

  function automatic logic [MS_W-1:0] wrap_inc(input logic [MS_W-1:0] v,
                                               input logic [MS_W-1:0] max);
    return (v == max) ? '0 : v + 6'd1;
  endfunction
endpackage

// File: rtl/rtc_alarm_clock_if.sv
// Control keys and display bundle between board/keys and the clock core.
interface rtc_alarm_clock_if;
  import clock_pkg::*;

  logic       LOAD;
  logic       MODE12;
  logic       ALM_SET;
  logic       ALM_ON;
  logic       key_H;
  logic       key_M;
  logic       key_S;
  logic [3:0] Hh;
  logic [3:0] Hl;
  logic [3:0] Mh;
  logic [3:0] Ml;
  logic [3:0] Sh;
  logic [3:0] Sl;
  logic       PM;
  logic       isFull;
  logic       ALARM;
  logic       TICK;
  alm_state_t alm_state;

  // No handshake: inputs are plain levels, outputs are registered each cycle.
  modport master (
    output LOAD, MODE12, ALM_SET, ALM_ON, key_H, key_M, key_S,
    input  Hh, Hl, Mh, Ml, Sh, Sl, PM, isFull, ALARM, TICK, alm_state
  );
  modport slave (
    input  LOAD, MODE12, ALM_SET, ALM_ON, key_H, key_M, key_S,
    output Hh, Hl, Mh, Ml, Sh, Sl, PM, isFull, ALARM, TICK, alm_state
  );
endinterface

// File: rtl/rtc_alarm_clock_bcd_split.sv
// Binary 0..59 to two BCD digits.
module bcd_split
  import clock_pkg::*;
(
  input  logic [MS_W-1:0] bin,
  output logic [3:0]      tens,
  output logic [3:0]      ones
);
  always_comb begin
    tens = 4'(bin / 6'd10);
    ones = 4'(bin % 6'd10);
  end
endmodule

// File: rtl/rtc_alarm_clock.sv
// H:M:S clock with 1 Hz prescaler, key set mode, 12/24h display, top-of-hour pulse.
// Optional alarm with bounded ring time is built when ALARM_EN is defined.
module rtc_alarm_clock
  import clock_pkg::*;
#(
  parameter int unsigned DIV       = 50_000_000,
  parameter int unsigned ALARM_LEN = 60
) (
  input  logic               CLK,
  input  logic               RST_N,
  rtc_alarm_clock_if.slave   bus
);
  logic [1:0]      rst_ff;
  logic            rst_n;
  logic [31:0]     cnt;
  logic            tick_c;
  logic [2:0]      keys, key_q, rise;
  logic            alm_set_mode;
  logic [H_W-1:0]  h, h_n, h_inc;
  logic [MS_W-1:0] m, m_n, m_inc, s, s_n, s_inc;
  logic [H_W-1:0]  dh, dh_disp;
  logic [MS_W-1:0] dm, ds;
  logic            pm_c;
  logic [3:0]      hh_c, hl_c, mh_c, ml_c, sh_c, sl_c;

  // Assert asynchronously, release after two clean edges.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rst_ff <= '0;
    else        rst_ff <= {rst_ff[0], 1'b1};
  end
  assign rst_n = rst_ff[1];

  assign tick_c = !bus.LOAD && (cnt == 32'(DIV - 1));
  assign keys   = {bus.key_H, bus.key_M, bus.key_S};
  assign rise   = keys & ~key_q;

  always_comb begin
    s_inc = wrap_inc(s, MS_W'(SEC_MAX));
    m_inc = wrap_inc(m, MS_W'(MIN_MAX));
    h_inc = H_W'(wrap_inc(MS_W'(h), MS_W'(HOURS_MAX)));
    s_n = s;
    m_n = m;
    h_n = h;
    if (tick_c) begin
      s_n = s_inc;
      if (s == MS_W'(SEC_MAX)) begin
        m_n = m_inc;
        if (m == MS_W'(MIN_MAX)) h_n = h_inc;
      end
    end else if (bus.LOAD && !alm_set_mode) begin
      // Fields adjust independently; no carry in set mode.
      if (rise[2]) h_n = h_inc;
      if (rise[1]) m_n = m_inc;
      if (rise[0]) s_n = '0;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      key_q <= '0;
      h     <= '0;
      m     <= '0;
      s     <= '0;
    end else begin
      if (bus.LOAD || tick_c) cnt <= '0;
      else                    cnt <= cnt + 32'd1;
      key_q <= keys;
      h     <= h_n;
      m     <= m_n;
      s     <= s_n;
    end
  end

`ifdef ALARM_EN
  logic [H_W-1:0]  ah, ah_inc;
  logic [MS_W-1:0] am, am_inc;
  logic [7:0]      ring_cnt;
  alm_state_t      state;

  assign alm_set_mode = bus.LOAD && bus.ALM_SET;
  assign ah_inc       = H_W'(wrap_inc(MS_W'(ah), MS_W'(HOURS_MAX)));
  assign am_inc       = wrap_inc(am, MS_W'(MIN_MAX));

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      ah       <= '0;
      am       <= '0;
      ring_cnt <= '0;
      state    <= ALM_IDLE;
    end else begin
      if (alm_set_mode) begin
        if (rise[2]) ah <= ah_inc;
        if (rise[1]) am <= am_inc;
      end
      case (state)
        ALM_IDLE: begin
          if (tick_c && bus.ALM_ON && (h_n == ah) && (m_n == am) && (s_n == '0)) begin
            state    <= ALM_RING;
            ring_cnt <= '0;
          end
        end
        ALM_RING: begin
          if ((|rise) || !bus.ALM_ON || bus.LOAD) begin
            state <= ALM_IDLE;
          end else if (tick_c) begin
            if (ring_cnt == 8'(ALARM_LEN - 1)) state <= ALM_IDLE;
            else                                ring_cnt <= ring_cnt + 8'd1;
          end
        end
        default: state <= ALM_IDLE;
      endcase
    end
  end

  assign bus.ALARM     = (state == ALM_RING);
  assign bus.alm_state = state;
`else
  logic unused_alm;
  assign unused_alm    = bus.ALM_SET ^ bus.ALM_ON;
  assign alm_set_mode  = 1'b0;
  assign bus.ALARM     = 1'b0;
  assign bus.alm_state = ALM_IDLE;
`endif

  // Display source: alarm view shows AH:AM:00, otherwise the running time.
  always_comb begin
    dh = h;
    dm = m;
    ds = s;
`ifdef ALARM_EN
    if (alm_set_mode) begin
      dh = ah;
      dm = am;
      ds = '0;
    end
`endif
    pm_c = (dh >= H_W'(12));
    if (bus.MODE12) begin
      if (dh == '0)              dh_disp = H_W'(12);
      else if (dh > H_W'(12))    dh_disp = dh - H_W'(12);
      else                       dh_disp = dh;
    end else begin
      dh_disp = dh;
    end
  end

  bcd_split u_bcd_h (.bin({1'b0, dh_disp}), .tens(hh_c), .ones(hl_c));
  bcd_split u_bcd_m (.bin(dm),              .tens(mh_c), .ones(ml_c));
  bcd_split u_bcd_s (.bin(ds),              .tens(sh_c), .ones(sl_c));

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      bus.Hh     <= '0;
      bus.Hl     <= '0;
      bus.Mh     <= '0;
      bus.Ml     <= '0;
      bus.Sh     <= '0;
      bus.Sl     <= '0;
      bus.PM     <= 1'b0;
      bus.isFull <= 1'b0;
      bus.TICK   <= 1'b0;
    end else begin
      bus.Hh     <= hh_c;
      bus.Hl     <= hl_c;
      bus.Mh     <= mh_c;
      bus.Ml     <= ml_c;
      bus.Sh     <= sh_c;
      bus.Sl     <= sl_c;
      bus.PM     <= pm_c;
      bus.isFull <= tick_c && (m_n == '0) && (s_n == '0);
      bus.TICK   <= tick_c;
    end
  end
endmodule

// File: tb/tb_rtc_alarm_clock.sv
// Self-checking bench: seconds-of-day reference model checked every cycle,
// hour display table, and directed rollover / alarm / async reset sequences.
module tb_rtc_alarm_clock;
  import clock_pkg::*;

  localparam int unsigned DIV       = 4;
  localparam int unsigned ALARM_LEN = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  rtc_alarm_clock_if bus();

  rtc_alarm_clock #(.DIV(DIV), .ALARM_LEN(ALARM_LEN)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  bit in_load, in_m12, in_aset, in_aon, in_kh, in_km, in_ks;

  // Reference model: time as seconds of day, alarm as minutes of day.
  int t, a, phase, ring_ticks;
  bit ring, pk_h, pk_m, pk_s;
  logic [27:0] exp_q[$];

  typedef struct {
    int         n_h;
    bit         m12;
    logic [3:0] hh;
    logic [3:0] hl;
    logic       pm;
  } hvec_t;
  hvec_t tbl[10];

  function automatic logic [27:0] out_vec();
    return {bus.Hh, bus.Hl, bus.Mh, bus.Ml, bus.Sh, bus.Sl,
            bus.PM, bus.isFull, bus.ALARM, bus.TICK};
  endfunction

  function automatic logic [23:0] digits();
    return {bus.Hh, bus.Hl, bus.Mh, bus.Ml, bus.Sh, bus.Sl};
  endfunction

  task automatic check(input string name, input logic [27:0] got, input logic [27:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    t = 0; a = 0; phase = 0; ring = 0; ring_ticks = 0;
    pk_h = 0; pk_m = 0; pk_s = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    int hv, mv, sv, dh, mm;
    bit av, rh, rm, rs, tick;
`ifdef ALARM_EN
    av = in_load && in_aset;
`else
    av = 1'b0;
`endif
    hv = av ? a / 60 : t / 3600;
    mv = av ? a % 60 : (t / 60) % 60;
    sv = av ? 0 : t % 60;
    dh = in_m12 ? ((hv % 12 == 0) ? 12 : hv % 12) : hv;
    rh = in_kh && !pk_h;
    rm = in_km && !pk_m;
    rs = in_ks && !pk_s;
    pk_h = in_kh; pk_m = in_km; pk_s = in_ks;
    tick  = !in_load && (phase == int'(DIV) - 1);
    phase = (in_load || tick) ? 0 : phase + 1;
    if (tick) begin
      t = (t + 1) % 86400;
    end else if (in_load && !av) begin
      if (rh) t = (t + 3600) % 86400;
      if (rm) begin mm = (t / 60) % 60; t = t - mm * 60 + ((mm + 1) % 60) * 60; end
      if (rs) t = t - t % 60;
    end else if (in_load && av) begin
      if (rh) a = (a + 60) % 1440;
      if (rm) begin mm = a % 60; a = a - mm + (mm + 1) % 60; end
    end
`ifdef ALARM_EN
    if (ring) begin
      if (rh || rm || rs || !in_aon || in_load) ring = 0;
      else if (tick) begin
        ring_ticks++;
        if (ring_ticks == int'(ALARM_LEN)) ring = 0;
      end
    end else if (tick && in_aon && t == a * 60) begin
      ring = 1;
      ring_ticks = 0;
    end
`endif
    exp_q.push_back({4'(dh / 10), 4'(dh % 10), 4'(mv / 10), 4'(mv % 10),
                     4'(sv / 10), 4'(sv % 10), 1'(hv >= 12),
                     1'(tick && (t % 3600 == 0)), 1'(ring), 1'(tick)});
  endtask

  task automatic apply_inputs();
    bus.LOAD = in_load; bus.MODE12 = in_m12; bus.ALM_SET = in_aset; bus.ALM_ON = in_aon;
    bus.key_H = in_kh;  bus.key_M = in_km;   bus.key_S = in_ks;
  endtask

  task automatic cycle();
    logic [27:0] exp;
    @(negedge clk);
    apply_inputs();
    model_step();
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check("cycle", out_vec(), exp);
  endtask

  task automatic press(input int which, input int n);
    for (int i = 0; i < n; i++) begin
      case (which)
        0:       in_kh = 1'b1;
        1:       in_km = 1'b1;
        default: in_ks = 1'b1;
      endcase
      cycle();
      in_kh = 1'b0; in_km = 1'b0; in_ks = 1'b0;
      cycle();
    end
  endtask

  // Caller positions time away from a clock edge before asserting reset.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("reset_async", out_vec(), '0);
    in_load = 0; in_m12 = 0; in_aset = 0; in_aon = 0;
    in_kh = 0; in_km = 0; in_ks = 0;
    apply_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("reset_state", out_vec(), '0);
  endtask

  task automatic alarm_setup_and_run();
    in_load = 1;
    press(1, 59);
    press(2, 1);
    in_load = 0;
    repeat (240) cycle();
  endtask

  initial begin
    tbl[0] = '{0,  1'b1, 4'd1, 4'd2, 1'b0};
    tbl[1] = '{0,  1'b0, 4'd0, 4'd0, 1'b0};
    tbl[2] = '{12, 1'b1, 4'd1, 4'd2, 1'b1};
    tbl[3] = '{0,  1'b0, 4'd1, 4'd2, 1'b1};
    tbl[4] = '{1,  1'b1, 4'd0, 4'd1, 1'b1};
    tbl[5] = '{0,  1'b0, 4'd1, 4'd3, 1'b1};
    tbl[6] = '{10, 1'b1, 4'd1, 4'd1, 1'b1};
    tbl[7] = '{0,  1'b0, 4'd2, 4'd3, 1'b1};
    tbl[8] = '{1,  1'b0, 4'd0, 4'd0, 1'b0};
    tbl[9] = '{11, 1'b1, 4'd1, 4'd1, 1'b0};

    #3;
    do_reset();

    // First ticks: TICK every DIV cycles, three ticks show 00:00:03.
    repeat (13) cycle();
    check("first_ticks", 28'(digits()), 28'(24'h000003));

    // Hour display table in set mode.
    in_load = 1;
    for (int i = 0; i < 10; i++) begin
      in_m12 = tbl[i].m12;
      press(0, tbl[i].n_h);
      cycle();
      check("tbl_hour", 28'({bus.Hh, bus.Hl, bus.PM}),
            28'({tbl[i].hh, tbl[i].hl, tbl[i].pm}));
    end

    // Minute wrap without carry, then a held key gives a single step.
    in_m12 = 0;
    press(1, 59);
    press(1, 1);
    check("no_carry", 28'(digits() >> 8), 28'(16'h1100));
    in_kh = 1;
    repeat (10) cycle();
    in_kh = 0;
    cycle();
    check("held_key", 28'(digits() >> 8), 28'(16'h1200));

    // 23:59:59 -> 00:00:00 with a single isFull pulse.
    press(0, 11);
    press(1, 59);
    press(2, 1);
    in_load = 0;
    repeat (240) cycle();
    check("full_pulse", 28'({bus.isFull, bus.TICK}), 28'(2'b11));
    cycle();
    check("rollover", 28'({digits(), bus.isFull}), 28'(0));

    // Alarm at 07:30, time preset to 07:29:00.
    @(negedge clk);
    #2;
    do_reset();
    in_load = 1; in_aset = 1;
    press(0, 7);
    press(1, 30);
    in_aset = 0;
    press(0, 7);
    press(1, 29);
    in_aon = 1; in_load = 0;
    repeat (240) cycle();
`ifdef ALARM_EN
    check("alarm_rise", 28'(bus.ALARM), 28'(1));
`endif
    repeat (11) cycle();
`ifdef ALARM_EN
    check("alarm_hold", 28'(bus.ALARM), 28'(1));
`endif
    cycle();
`ifdef ALARM_EN
    check("alarm_len_end", 28'(bus.ALARM), 28'(0));
`endif

    // Second ring cancelled by a key.
    alarm_setup_and_run();
    in_ks = 1;
    cycle();
    in_ks = 0;
`ifdef ALARM_EN
    check("alarm_key_cancel", 28'(bus.ALARM), 28'(0));
`endif
    cycle();

    // Third ring cut by asynchronous reset, then restart from zero.
    alarm_setup_and_run();
`ifdef ALARM_EN
    check("alarm_ring3", 28'(bus.ALARM), 28'(1));
`endif
    #2;
    do_reset();
    repeat (13) cycle();
    check("restart", 28'(digits()), 28'(24'h000003));

    // Randomised run against the model.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 49) == 0) in_load = !in_load;
      if ($urandom_range(0, 19) == 0) in_m12  = !in_m12;
      if ($urandom_range(0, 29) == 0) in_aset = !in_aset;
      if ($urandom_range(0, 39) == 0) in_aon  = !in_aon;
      in_kh = ($urandom_range(0, 3) == 0);
      in_km = ($urandom_range(0, 3) == 0);
      in_ks = ($urandom_range(0, 5) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
